// File: rtl/instruction_memory_pkg.sv
// Shared types and constants for the instruction store
// and the fetch path of the control unit.
package instr_mem_pkg;

   localparam int INSTR_WIDTH = 32;

   localparam logic [INSTR_WIDTH-1:0] ILLEGAL_WORD = 32'hFFFF_FFFF;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // addi x0, x0, 0
   localparam logic [6:0] NOP_OPCODE = OP_IMM;
   localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } imem_state_t;

   function automatic logic fetch_legal(
      input logic [31:0] addr,
      input int          idx_w
   );
      return (addr[1:0] == 2'b00) &&
             ((addr >> (idx_w + 2)) == 32'd0);
   endfunction

endpackage

// File: rtl/instruction_memory_latency_counter.sv
// Countdown for the WAIT phase of a fetch: load, decrement,
// and a zero flag that marks the completion cycle.
module imem_latency_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/instruction_memory.sv
// Word-organised instruction store with a fixed fetch
// latency and an independent program-load write port.
module instruction_memory
   import instr_mem_pkg::*;
#(
   parameter int DEPTH_WORDS  = 256,
   parameter int READ_LATENCY = 3
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic                           READ,
   input  logic [31:0]                    ADDRESS,
   output logic [INSTR_WIDTH-1:0]         INSTRUCTION,
   output logic                           BUSYWAIT,
   output logic                           ADDR_ERROR,
   input  logic                           LOAD_EN,
   input  logic [$clog2(DEPTH_WORDS)-1:0] LOAD_ADDR,
   input  logic [INSTR_WIDTH-1:0]         LOAD_DATA
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W =
      (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      CNT_W'(READ_LATENCY - 1);

   imem_state_t state;
   imem_state_t state_next;

   logic             accept;
   logic             complete;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [31:0]      addr_q;
   logic             legal;
   logic [IDX_W-1:0] rd_idx;

   logic [INSTR_WIDTH-1:0] mem [DEPTH_WORDS];

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (READ) state_next = WAIT;
         end
         WAIT: begin
            if (cnt_zero) state_next = DONE;
         end
         DONE: begin
            state_next = READ ? WAIT : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      BUSYWAIT = (state == WAIT) ||
                 ((state == IDLE) && READ);
      accept   = READ &&
                 ((state == IDLE) || (state == DONE));
      complete = (state == WAIT) && cnt_zero;
      cnt_dec  = (state == WAIT) && !cnt_zero;
   end

   imem_latency_counter #(
      .WIDTH (CNT_W)
   ) u_latency (
      .clk        (CLK),
      .rst        (RESET),
      .load       (accept),
      .load_value (CNT_INIT),
      .dec        (cnt_dec),
      .zero       (cnt_zero)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         addr_q <= '0;
      end else if (accept) begin
         addr_q <= ADDRESS;
      end
   end

   assign legal  = fetch_legal(addr_q, IDX_W);
   assign rd_idx = addr_q[IDX_W+1:2];

   // Storage is deliberately not reset
   always_ff @(posedge CLK) begin
      if (LOAD_EN) begin
         mem[LOAD_ADDR] <= LOAD_DATA;
      end
   end

   // A load on the completion edge lands after this read
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         INSTRUCTION <= '0;
         ADDR_ERROR  <= 1'b0;
      end else if (complete) begin
         INSTRUCTION <= legal ? mem[rd_idx] : ILLEGAL_WORD;
         ADDR_ERROR  <= !legal;
      end
   end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: table of fetches
// plus hand-written latency, race and reset sequences.
module tb_instruction_memory;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RESET, READ, LOAD_EN;
   logic [31:0] ADDRESS, LOAD_DATA, INSTRUCTION;
   logic [7:0]  LOAD_ADDR;
   logic        BUSYWAIT, ADDR_ERROR;

   logic        r1_read, r1_load_en;
   logic [31:0] r1_address, r1_load_data, r1_instruction;
   logic [7:0]  r1_load_addr;
   logic        r1_busywait, r1_addr_error;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   instruction_memory #(
      .DEPTH_WORDS  (256),
      .READ_LATENCY (3)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .READ        (READ),
      .ADDRESS     (ADDRESS),
      .INSTRUCTION (INSTRUCTION),
      .BUSYWAIT    (BUSYWAIT),
      .ADDR_ERROR  (ADDR_ERROR),
      .LOAD_EN     (LOAD_EN),
      .LOAD_ADDR   (LOAD_ADDR),
      .LOAD_DATA   (LOAD_DATA)
   );

   instruction_memory #(
      .DEPTH_WORDS  (256),
      .READ_LATENCY (1)
   ) dut_r1 (
      .CLK         (CLK),
      .RESET       (RESET),
      .READ        (r1_read),
      .ADDRESS     (r1_address),
      .INSTRUCTION (r1_instruction),
      .BUSYWAIT    (r1_busywait),
      .ADDR_ERROR  (r1_addr_error),
      .LOAD_EN     (r1_load_en),
      .LOAD_ADDR   (r1_load_addr),
      .LOAD_DATA   (r1_load_data)
   );

   typedef struct {
      bit          ld;
      logic [7:0]  la;
      logic [31:0] ldat;
      logic [31:0] addr;
      logic [31:0] ins;
      logic        err;
   } vec_t;

   vec_t vt [7];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load(input logic [7:0] a,
                       input logic [31:0] d);
      LOAD_EN   = 1'b1;
      LOAD_ADDR = a;
      LOAD_DATA = d;
      @(posedge CLK);
      #1;
      LOAD_EN = 1'b0;
   endtask

   // Returns at the DONE negedge (hold) or just after it (no hold)
   task automatic fetch(input logic [31:0] a, input bit hold,
                        output int bw, output int dc);
      ADDRESS = a;
      READ    = 1'b1;
      bw      = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!BUSYWAIT) break;
         bw++;
      end
      dc = cyc;
      if (!hold) begin
         READ = 1'b0;
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      int bw, d0, d1, d2, rc, seen;

      vt[0] = '{1'b1, 8'd5,   32'h0002_0103, 32'd20,
                32'h0002_0103, 1'b0};
      vt[1] = '{1'b0, 8'd0,   32'h0,         32'd6,
                32'hFFFF_FFFF, 1'b1};
      vt[2] = '{1'b1, 8'd3,   32'h0040_0093, 32'd12,
                32'h0040_0093, 1'b0};
      vt[3] = '{1'b0, 8'd0,   32'h0,         32'd1024,
                32'hFFFF_FFFF, 1'b1};
      vt[4] = '{1'b1, 8'd255, 32'hDEAD_BEEF, 32'd1020,
                32'hDEAD_BEEF, 1'b0};
      vt[5] = '{1'b0, 8'd0,   32'h0,         32'h8000_0000,
                32'hFFFF_FFFF, 1'b1};
      vt[6] = '{1'b1, 8'd7,   32'h1234_5678, 32'd28,
                32'h1234_5678, 1'b0};

      RESET        = 1'b1;
      READ         = 1'b0;
      ADDRESS      = '0;
      LOAD_EN      = 1'b0;
      LOAD_ADDR    = '0;
      LOAD_DATA    = '0;
      r1_read      = 1'b0;
      r1_address   = '0;
      r1_load_en   = 1'b0;
      r1_load_addr = '0;
      r1_load_data = '0;

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_instr", INSTRUCTION, 32'h0);
      check("rst_err", 32'(ADDR_ERROR), 32'h0);
      check("rst_bw_idle", 32'(BUSYWAIT), 32'h0);
      READ = 1'b1;
      #1;
      check("rst_bw_follow", 32'(BUSYWAIT), 32'h1);
      READ  = 1'b0;
      RESET = 1'b0;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 7; i++) begin
         if (vt[i].ld) load(vt[i].la, vt[i].ldat);
         fetch(vt[i].addr, 1'b0, bw, d0);
         check($sformatf("vec%0d_bw", i), 32'(bw), 32'd4);
         check($sformatf("vec%0d_ins", i), INSTRUCTION,
               vt[i].ins);
         check($sformatf("vec%0d_err", i), 32'(ADDR_ERROR),
               32'(vt[i].err));
      end

      load(8'd0, 32'hAAAA_0001);
      load(8'd1, 32'hBBBB_0002);
      load(8'd2, 32'hCCCC_0003);
      fetch(32'd0, 1'b1, bw, d0);
      check("b2b0_bw", 32'(bw), 32'd4);
      check("b2b0_ins", INSTRUCTION, 32'hAAAA_0001);
      fetch(32'd4, 1'b1, bw, d1);
      check("b2b1_bw", 32'(bw), 32'd3);
      check("b2b1_ins", INSTRUCTION, 32'hBBBB_0002);
      check("b2b1_gap", 32'(d1 - d0), 32'd4);
      fetch(32'd8, 1'b0, bw, d2);
      check("b2b2_bw", 32'(bw), 32'd3);
      check("b2b2_ins", INSTRUCTION, 32'hCCCC_0003);
      check("b2b2_gap", 32'(d2 - d1), 32'd4);

      ADDRESS = 32'd8;
      READ    = 1'b1;
      @(posedge CLK);
      #1;
      READ      = 1'b0;
      ADDRESS   = 32'd12;
      LOAD_EN   = 1'b1;
      LOAD_ADDR = 8'd2;
      LOAD_DATA = 32'h5555_AAAA;
      @(posedge CLK);
      #1;
      LOAD_EN = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!BUSYWAIT) break;
      end
      check("race_early", INSTRUCTION, 32'h5555_AAAA);
      @(posedge CLK);
      #1;

      ADDRESS = 32'd8;
      READ    = 1'b1;
      @(posedge CLK);
      #1;
      READ = 1'b0;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      LOAD_EN   = 1'b1;
      LOAD_ADDR = 8'd2;
      LOAD_DATA = 32'h7777_0000;
      @(posedge CLK);
      #1;
      LOAD_EN = 1'b0;
      check("race_done_bw", 32'(BUSYWAIT), 32'h0);
      check("race_late_old", INSTRUCTION, 32'h5555_AAAA);
      @(posedge CLK);
      #1;
      fetch(32'd8, 1'b0, bw, d0);
      check("race_late_new", INSTRUCTION, 32'h7777_0000);

      fetch(32'd6, 1'b0, bw, d0);
      check("pre_rst_err", 32'(ADDR_ERROR), 32'h1);
      ADDRESS = 32'd20;
      READ    = 1'b1;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      #1;
      check("midrst_instr", INSTRUCTION, 32'h0);
      check("midrst_err", 32'(ADDR_ERROR), 32'h0);
      check("midrst_bw", 32'(BUSYWAIT), 32'h1);
      @(negedge CLK);
      RESET = 1'b0;
      rc    = cyc;
      bw    = 0;
      seen  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!BUSYWAIT) break;
         bw++;
         if (INSTRUCTION !== 32'h0) seen = 1;
      end
      check("restart_bw", 32'(bw), 32'd3);
      check("restart_nodone", 32'(seen), 32'd0);
      check("restart_gap", 32'(cyc - rc), 32'd4);
      check("restart_ins", INSTRUCTION, 32'h0002_0103);
      READ = 1'b0;
      @(posedge CLK);
      #1;

      r1_load_en   = 1'b1;
      r1_load_addr = 8'd1;
      r1_load_data = 32'h0000_0013;
      @(posedge CLK);
      #1;
      r1_load_addr = 8'd2;
      r1_load_data = 32'h00A0_0093;
      @(posedge CLK);
      #1;
      r1_load_en = 1'b0;
      r1_address = 32'd4;
      r1_read    = 1'b1;
      bw         = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!r1_busywait) break;
         bw++;
      end
      check("rl1_bw_idle", 32'(bw), 32'd2);
      check("rl1_ins0", r1_instruction, 32'h0000_0013);
      r1_address = 32'd8;
      bw         = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!r1_busywait) break;
         bw++;
      end
      check("rl1_bw_b2b", 32'(bw), 32'd1);
      check("rl1_ins1", r1_instruction, 32'h00A0_0093);
      check("rl1_err", 32'(r1_addr_error), 32'h0);
      r1_read = 1'b0;
      @(posedge CLK);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Word-organised instruction store that answers the CPU's instruction fetches. The CPU drives a byte address and a read strobe. This block stalls the CPU with `BUSYWAIT` for a programmable latency, then returns the 32-bit instruction word. A separate load port lets the testbench or a boot loader write program words.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, at least 4.
- `READ_LATENCY`, 3: number of WAIT cycles per fetch; at least 1.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `READ`  in  1  fetch request; held high with stable `ADDRESS` while `BUSYWAIT` is high.
- `ADDRESS`  in  32  byte address, i.e. the PC.
- `INSTRUCTION`  out  32  fetched word; registered.
- `BUSYWAIT`  out  1  stall to the CPU; combinational from state and `READ`.
- `ADDR_ERROR`  out  1  the completed fetch was misaligned or out of range; registered.
- `LOAD_EN`  in  1  program-load write strobe.
- `LOAD_ADDR`  in  log2(DEPTH_WORDS)  word index for the load.
- `LOAD_DATA`  in  32  word to write.

## Operation
States: IDLE, WAIT, DONE.

- **IDLE**
  - `READ`=1 at an edge: latch `ADDRESS`, load counter with READ_LATENCY-1, go to WAIT.
- **WAIT**
  - Counter above 0 at an edge: decrement.
  - Counter equal to 0 at an edge: register `INSTRUCTION` and `ADDR_ERROR`, go to DONE.
- **DONE**
  - Lasts one cycle; `INSTRUCTION` is valid and `BUSYWAIT` is low.
  - `READ`=1 at the edge: accept a new fetch exactly as in IDLE and go to WAIT (back-to-back fetch).
  - Otherwise go to IDLE.
- **`BUSYWAIT`** = (state==WAIT) OR (state==IDLE AND `READ`). It is never high in DONE.
- **Word index**: `ADDRESS[log2(DEPTH_WORDS)+1:2]`.
- **Error case**: if `ADDRESS[1:0]`≠0, or any bit above the index range is set:
  - `INSTRUCTION` = ILLEGAL_WORD (32'hFFFF_FFFF, which decodes to no register write);
  - `ADDR_ERROR`=1;
  - the full latency is still spent.
- **`ADDR_ERROR`** is cleared at every completion that has a legal address.
- **Storage**
  - Read at the completion edge; the address used is the one latched at acceptance.
  - A load at any earlier edge is visible to the fetch.
  - A load at the completion edge itself is not visible; the old word is returned.
  - The load port is always enabled and independent of the FSM.
  - `LOAD_ADDR` wraps naturally within the index width.
- `INSTRUCTION` and `ADDR_ERROR` hold their values through IDLE and WAIT until the next completion.

## Timing
- **Reset**: state=IDLE, counter=0, `INSTRUCTION`=0, `ADDR_ERROR`=0.
  - `BUSYWAIT` then follows `READ` combinationally.
  - Storage contents are not reset.
- **Reset mid-fetch**: the fetch is aborted and no DONE follows.
  - If `READ` is still high after reset is released, the fetch is re-accepted from IDLE.
- **Latency**: with the fetch accepted at edge E0, DONE begins after edge E0+READ_LATENCY.
  - A fetch from IDLE holds `BUSYWAIT` high for READ_LATENCY+1 cycles.
  - A back-to-back fetch from DONE holds `BUSYWAIT` high for READ_LATENCY cycles.
- **Throughput**: one instruction every READ_LATENCY+1 cycles under continuous `READ`.
- Changes to `READ` or `ADDRESS` during WAIT are ignored.

## Structure
- Package `instr_mem_pkg` holds:
  - the state enum (IDLE/WAIT/DONE);
  - `INSTR_WIDTH`=32;
  - `ILLEGAL_WORD`=32'hFFFF_FFFF;
  - `NOP_OPCODE` and the opcode constants shared with the control unit.
- One sub-module, `imem_latency_counter`: load, decrement and zero-flag for the WAIT countdown.
- The storage array and the address checks stay in the top module.

## Test plan
All scenarios use READ_LATENCY=3 unless stated.

- **Basic fetch**: load word 5 = 32'h0002_0103, then hold `READ` with `ADDRESS`=20 from IDLE.
  - `BUSYWAIT` high for 4 cycles.
  - Then `INSTRUCTION`=32'h0002_0103 and `ADDR_ERROR`=0 in the DONE cycle.
- **Back-to-back**: `READ` stays high; `ADDRESS` steps 0, 4, 8 at each DONE cycle.
  - Three completions, 4 cycles apart, each returning the loaded words in order.
- **Errors**:
  - `ADDRESS`=6 returns 32'hFFFF_FFFF with `ADDR_ERROR`=1 after full latency.
  - `ADDRESS`=1024 (with DEPTH_WORDS=256) gives the same result.
  - The next legal fetch clears `ADDR_ERROR`.
- **Load race**: fetch `ADDRESS`=8.
  - A load of word 2 during the first WAIT cycle is returned.
  - A load of word 2 on the completion edge is not returned; the old word is.
- **Reset mid-WAIT**: pulse `RESET` during the second WAIT cycle.
  - Outputs go to 0 at once and no DONE occurs.
  - With `READ` held high, the fetch restarts and completes READ_LATENCY+1 cycles later.
- **READ_LATENCY=1**: `BUSYWAIT` is high for 2 cycles from IDLE, and a fetch from DONE is accepted.
